// File: rtl/lb_timer_pkg.sv
// Shared definitions for the round-robin tick-timer arbiter: default sizes and FSM state encoding.
package lb_timer_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_N    = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lb_tick_counter.sv
// Loadable up-counter: load latches the terminal count and clears the count;
// enable advances the count until it reaches the terminal count.
module lb_tick_counter
    import lb_timer_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [N-1:0] tc_i,
    output logic         at_tc_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] tc_q;

    assign at_tc_o = (cnt_q == tc_q);

    // The count stops at the terminal value, so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tc_q  <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            tc_q  <= tc_i;
        end else if (en_i && !at_tc_o) begin
            cnt_q <= cnt_q + N'(1);
        end
    end

endmodule

// File: rtl/lb_timer_arbiter.sv
// Shares one tick counter among NREQ requesters; round-robin grant, one done pulse per
// completed count, abandon when the owner drops its request.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// COUNT | owner holds the counter, counting toward its terminal count
// DONE  | one-cycle done pulse to the owner, then release
module lb_timer_arbiter
    import lb_timer_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int N    = DEF_N,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] value,
    input  logic              en,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [IDW-1:0]    cur_id
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] cur_id_q, cur_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [N-1:0]   tc_sel;
    logic           cnt_load;
    logic           cnt_en;
    logic           at_tc;

    // Round-robin search starting at rr_ptr_q, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
        end
    end

    always_comb begin
        tc_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_id == IDW'(k)) begin
                tc_sel = value[k*N +: N];
            end
        end
    end

    assign rr_next = (cur_id_q == LAST_ID) ? '0 : cur_id_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cur_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_COUNT;
                    cur_id_d = win_id;
                end
            end
            ST_COUNT: begin
                // Abandon outranks completion when the owner lets go.
                if (!req[cur_id_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = rr_next;
                end else if (en && at_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = rr_next;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        done     = '0;
        busy     = (state_q != ST_IDLE);
        cnt_load = (state_q == ST_IDLE) && win_found;
        cnt_en   = (state_q == ST_COUNT) && req[cur_id_q] && en;
        for (int k = 0; k < NREQ; k++) begin
            grant[k] = busy && (cur_id_q == IDW'(k));
            done[k]  = (state_q == ST_DONE) && (cur_id_q == IDW'(k));
        end
    end

    assign cur_id = cur_id_q;

    lb_tick_counter #(.N(N)) u_tick_counter (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .tc_i   (tc_sel),
        .at_tc_o(at_tc)
    );

endmodule

// File: tb/tb_lb_timer_arbiter.sv
// Scoreboard bench for lb_timer_arbiter: stimulus queues expected grant/done events with
// their cycle numbers, a negedge monitor pops and compares them as the DUT produces them.
module tb_lb_timer_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 20;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] value;
    logic              en;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        cur_id;

    typedef struct {
        int              kind;
        logic [NREQ-1:0] val;
        int              cyc;
    } ev_t;

    ev_t             exp_q[$];
    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;
    logic [NREQ-1:0] prev_grant = '0;

    lb_timer_arbiter #(.NREQ(NREQ), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .value (value),
        .en    (en),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .cur_id(cur_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic string kname(int k);
        case (k)
            EV_RISE: return "grant_rise";
            EV_FALL: return "grant_fall";
            default: return "done";
        endcase
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_ev(int kind, logic [NREQ-1:0] v, int c);
        ev_t e;
        e.kind = kind;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind, logic [NREQ-1:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got val=%b at cycle %0d, none required", kname(kind), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== v || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s val=%b cycle=%0d, want %s val=%b cycle=%0d",
                         kname(e.kind), kname(kind), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("done_in_grant", 32'($onehot0(done) && ((done & ~grant) == '0)), 32'd1);
        check("busy_vs_grant", 32'(busy), 32'(grant != '0));
        if (prev_grant != '0 && grant == '0) observe(EV_FALL, '0);
        if (grant != '0 && grant != prev_grant) observe(EV_RISE, grant);
        if (done != '0) observe(EV_DONE, done);
        prev_grant = grant;
    end

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(string name, int c);
        wait_to(c);
        check({"leftover_", name}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cur_id"}, 32'(cur_id), 32'd0);
    endtask

    int k;

    initial begin
        reset = 1'b1;
        req   = '0;
        value = '0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        wait_to(cyc + 4);

        // Single request, tc=5: grant for 7 cycles, done on the 7th.
        k = cyc;
        value[0*N +: N] = N'(5);
        req = 4'b0001;
        expect_ev(EV_RISE, 4'b0001, k + 1);
        expect_ev(EV_DONE, 4'b0001, k + 7);
        expect_ev(EV_FALL, 4'b0000, k + 8);
        wait_to(k + 3);
        check("single_cur_id", 32'(cur_id), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        wait_to(k + 7);
        req = '0;
        drain("single", k + 11);

        // Round-robin over four held requests, tc=2 each.
        pulse_reset();
        k = cyc;
        for (int i = 0; i < NREQ; i++) value[i*N +: N] = N'(2);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_ev(EV_RISE, 4'(1 << (i % 4)), k + 1 + 5 * i);
            expect_ev(EV_DONE, 4'(1 << (i % 4)), k + 4 + 5 * i);
            expect_ev(EV_FALL, 4'b0000, k + 5 + 5 * i);
        end
        wait_to(k + 24);
        req = '0;
        drain("round_robin", k + 28);

        // Pause: en low for 4 cycles mid-count delays done by 4.
        pulse_reset();
        k = cyc;
        value[0*N +: N] = N'(3);
        req = 4'b0001;
        expect_ev(EV_RISE, 4'b0001, k + 1);
        expect_ev(EV_DONE, 4'b0001, k + 9);
        expect_ev(EV_FALL, 4'b0000, k + 10);
        wait_to(k + 2);
        en = 1'b0;
        wait_to(k + 6);
        en = 1'b1;
        wait_to(k + 9);
        req = '0;
        drain("pause", k + 13);

        // Abandon at cnt=2; requester 1 follows after one idle cycle and ignores a late value change.
        pulse_reset();
        k = cyc;
        value[0*N +: N] = N'(10);
        value[1*N +: N] = N'(1);
        req = 4'b0011;
        expect_ev(EV_RISE, 4'b0001, k + 1);
        expect_ev(EV_FALL, 4'b0000, k + 4);
        expect_ev(EV_RISE, 4'b0010, k + 5);
        expect_ev(EV_DONE, 4'b0010, k + 7);
        expect_ev(EV_FALL, 4'b0000, k + 8);
        wait_to(k + 3);
        req = 4'b0010;
        wait_to(k + 5);
        value[1*N +: N] = N'(7);
        wait_to(k + 7);
        req = '0;
        drain("abandon", k + 10);

        // Reset mid-count with the pointer at 2, then a tc=0 grant that must go to requester 0.
        k = cyc;
        value[0*N +: N] = '0;
        value[2*N +: N] = N'(5);
        req = 4'b0100;
        expect_ev(EV_RISE, 4'b0100, k + 1);
        expect_ev(EV_FALL, 4'b0000, k + 4);
        expect_ev(EV_RISE, 4'b0001, k + 5);
        expect_ev(EV_DONE, 4'b0001, k + 6);
        expect_ev(EV_FALL, 4'b0000, k + 7);
        wait_to(k + 3);
        reset = 1'b1;
        wait_to(k + 4);
        check_zero("midcount_reset");
        reset = 1'b0;
        req = 4'b0111;
        wait_to(k + 6);
        check("tc0_cur_id", 32'(cur_id), 32'd0);
        req = '0;
        drain("reset_tc0", k + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lb_timer_arbiter.md
LB_TIMER_ARBITER -- requirements
Module: lb_timer_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one tick counter.
REQ-002 The block SHALL have parameter N, default 20, giving the tick-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NREQ bits: level request per requester, held high until done or abandon.
REQ-006 The block SHALL have port value, input, NREQ*N bits: packed terminal counts, with requester k at bits [k*N +: N].
REQ-007 The block SHALL have port en, input, 1 bit: count enable; low freezes the counter in COUNT.
REQ-008 The block SHALL have port grant, output, NREQ bits: one-hot owner of the counter, all-zero when idle.
REQ-009 The block SHALL have port done, output, NREQ bits: one-cycle completion pulse to the owner.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port cur_id, output, clog2(NREQ) bits: index of the current or last owner.

Function
REQ-012 The FSM SHALL have states IDLE, COUNT and DONE.
REQ-013 In IDLE with any req bit high, at the clock edge the block SHALL:
- select the winner by round-robin, starting at pointer rr_ptr;
- set grant to the winner's one-hot code and cur_id to its index;
- latch the winner's value slice into tc;
- clear cnt to 0;
- enter COUNT.
REQ-014 In IDLE with req all-zero, the block SHALL stay in IDLE, and grant and done SHALL remain 0.
REQ-015 In COUNT with en high and cnt != tc, cnt SHALL increment by 1 each cycle.
REQ-016 In COUNT with en high and cnt == tc, the next state SHALL be DONE.
REQ-017 In COUNT with en low, cnt and state SHALL hold.
REQ-018 With en held high, the done pulse SHALL occur tc+1 cycles after grant rises; tc=0 gives a 1-cycle COUNT.
REQ-019 In DONE, done[cur_id] SHALL be high for exactly one cycle.
- grant SHALL remain asserted during DONE.
- On exit, rr_ptr SHALL become cur_id+1 modulo NREQ, and the next state SHALL be IDLE.
REQ-020 If req[cur_id] falls during COUNT, the block SHALL abandon the count.
- The next state SHALL be IDLE, with no done pulse.
- grant SHALL clear.
- rr_ptr SHALL advance as in REQ-019.
REQ-021 Changes on value after the grant SHALL be ignored; tc holds until the next grant.
REQ-022 New requests arriving during COUNT or DONE SHALL NOT preempt the owner; they are arbitrated in the next IDLE.
REQ-023 The block SHALL always spend at least one IDLE cycle between owners.
REQ-024 A requester still asserting req after its own done SHALL be eligible again only in round-robin order.
REQ-025 cnt and tc SHALL be N bits wide; cnt SHALL never wrap, because it stops at tc.
REQ-026 grant SHALL be at most one-hot in every cycle.
REQ-027 done SHALL be at most one-hot, and SHALL be a subset of grant.

Reset
REQ-028 When reset is high at an edge, the block SHALL set:
- state = IDLE, cnt = 0, tc = 0, rr_ptr = 0;
- grant = 0, done = 0, busy = 0, cur_id = 0.
REQ-029 Reset SHALL take precedence over all other inputs, including reset asserted mid-COUNT or mid-DONE; no done pulse SHALL follow.

Structure
REQ-030 State encodings and the default N and NREQ SHALL reside in shared package lb_timer_pkg.
REQ-031 The loadable up-counter (load, enable, terminal-compare) SHALL be a sub-module named lb_tick_counter.
- The FSM and round-robin arbiter SHALL remain in lb_timer_arbiter.

Verification
REQ-032 The bench SHALL cover single request:
- Stimulus: req=0001, value0=5, en=1.
- Required: grant=0001 for 7 cycles; done=0001 on the 7th cycle after grant rises.
REQ-033 The bench SHALL cover round-robin:
- Stimulus: req=1111 held, all values=2.
- Required: grants in order 0001, 0010, 0100, 1000, 0001; each owner gets one done pulse per turn.
REQ-034 The bench SHALL cover pause:
- Stimulus: value0=3, en low for 4 cycles mid-COUNT.
- Required: done is delayed by exactly 4 cycles.
REQ-035 The bench SHALL cover abandon:
- Stimulus: req0 dropped at cnt=2 with value0=10, req1 pending.
- Required: no done0; grant=0010 after one IDLE cycle.
REQ-036 The bench SHALL cover reset mid-COUNT and the tc=0 case:
- Reset mid-COUNT: all outputs are 0 next cycle, and the following grant goes to requester 0.
- value=0: done arrives 1 cycle after grant.
